// File: rtl/fp_int_acc_align.sv
// Two-stage align-and-accumulate for FP x INT products: stage A aligns and negates, stage B adds into a grouped sum.
// Optional saturation on overflow: define ACC_SAT_EN (default build wraps in two's complement).
module fp_int_acc_align #(
  parameter int ACC_WIDTH  = 32,
  parameter int SHIFT_DROP = 14,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        set,
  input  logic [LEN_WIDTH-1:0]        acc_len,
  input  logic                        start_acc,
  input  logic                        sign_in,
  input  logic [4:0]                  exp_in,
  input  logic [13:0]                 mantissa_in,
  output logic signed [ACC_WIDTH-1:0] acc_out,
  output logic                        acc_valid,
  output logic                        ovf_out,
  output logic                        busy
);

  // state | meaning
  // IDLE  | no group open, stage A empty
  // ACCUM | group open or a term waiting in stage A
  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  localparam int MAG_W = 45 - SHIFT_DROP;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic                        a_valid;
  logic signed [ACC_WIDTH-1:0] a_term;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0]        cnt;
  logic [LEN_WIDTH-1:0]        len_reg;
  logic                        sticky;

  logic [44:0]                 wide_mant;
  logic [MAG_W-1:0]            mag;
  logic signed [ACC_WIDTH-1:0] mag_ext;
  logic signed [ACC_WIDTH-1:0] term_a;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] wr_val;
  logic                        ovf;
  logic                        last;
  logic [LEN_WIDTH-1:0]        len_m1;

  // Stage A: align on a 45-bit grid, then drop the fraction LSBs
  assign wide_mant = {31'd0, mantissa_in};
  assign mag       = MAG_W'((wide_mant << exp_in) >> SHIFT_DROP);
  assign mag_ext   = {{(ACC_WIDTH-MAG_W){1'b0}}, mag};
  assign term_a    = sign_in ? -mag_ext : mag_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_valid <= 1'b0;
      a_term  <= '0;
    end else if (set) begin
      a_valid <= 1'b0;
    end else begin
      a_valid <= start_acc;
      if (start_acc) a_term <= term_a;
    end
  end

  // Stage B
  assign sum    = acc + a_term;
  assign ovf    = (acc[ACC_WIDTH-1] == a_term[ACC_WIDTH-1]) &&
                  (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
  assign len_m1 = len_reg - LEN_ONE;
  assign last   = (cnt == len_m1);

`ifdef ACC_SAT_EN
  assign wr_val = ovf ? (acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign wr_val = sum;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      len_reg   <= '0;
      acc_out   <= '0;
      ovf_out   <= 1'b0;
      acc_valid <= 1'b0;
    end else if (set) begin
      len_reg   <= acc_len;
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      if (a_valid) begin
        if (last) begin
          acc_out   <= wr_val;
          ovf_out   <= sticky | ovf;
          acc_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          sticky    <= 1'b0;
        end else begin
          acc    <= wr_val;
          cnt    <= cnt + LEN_ONE;
          sticky <= sticky | ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = ACCUM;
      ACCUM:   if (a_valid && last && !start_acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (set) state_nxt = IDLE;
  end

  assign busy = (state == ACCUM) | a_valid;

endmodule

// File: tb/tb_fp_int_acc_align.sv
// Directed plus random bench for fp_int_acc_align against an integer-arithmetic group-sum model.
module tb_fp_int_acc_align;

  localparam int  W    = 32;
  localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W-1));

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        set = 1'b0;
  logic [7:0]  acc_len = '0;
  logic        start_acc = 1'b0;
  logic        sign_in = 1'b0;
  logic [4:0]  exp_in = '0;
  logic [13:0] mantissa_in = '0;
  logic [W-1:0] acc_out;
  logic        acc_valid;
  logic        ovf_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // reference model: registers as seen during the current cycle
  int       m_len;
  longint   m_acc;
  int       m_cnt;
  bit       m_sticky;
  bit       m_pend;
  longint   m_pend_term;
  logic [W-1:0] m_out;
  bit       m_ovf;
  bit       m_valid;

  fp_int_acc_align dut (
    .clk(clk), .rst(rst), .set(set), .acc_len(acc_len), .start_acc(start_acc),
    .sign_in(sign_in), .exp_in(exp_in), .mantissa_in(mantissa_in),
    .acc_out(acc_out), .acc_valid(acc_valid), .ovf_out(ovf_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic longint term_of(input bit sg, input int e, input int m);
    longint mag;
    mag = (longint'(m) * (64'sd1 <<< e)) / (64'sd1 <<< 14);
    return sg ? -mag : mag;
  endfunction

  task automatic model_reset();
    m_len = 256; m_acc = 0; m_cnt = 0; m_sticky = 0; m_pend = 0; m_pend_term = 0;
    m_out = '0; m_ovf = 0; m_valid = 0;
  endtask

  task automatic model_edge(input bit s, input int len, input bit st, input bit sg,
                            input int e, input int m);
    longint sum;
    bit     o;
    m_valid = 0;
    if (s) begin
      m_len = (len == 0) ? 256 : len;
      m_acc = 0; m_cnt = 0; m_sticky = 0; m_pend = 0;
    end else begin
      if (m_pend) begin
        sum = m_acc + m_pend_term;
        o = 0;
        if (sum > MAXV) begin
          o = 1;
`ifdef ACC_SAT_EN
          sum = MAXV;
`else
          sum = sum - (64'sd1 <<< W);
`endif
        end else if (sum < MINV) begin
          o = 1;
`ifdef ACC_SAT_EN
          sum = MINV;
`else
          sum = sum + (64'sd1 <<< W);
`endif
        end
        if (m_cnt + 1 == m_len) begin
          m_out = sum[W-1:0]; m_ovf = m_sticky | o; m_valid = 1;
          m_acc = 0; m_cnt = 0; m_sticky = 0;
        end else begin
          m_acc = sum; m_cnt++; m_sticky = m_sticky | o;
        end
      end
      m_pend = st;
      m_pend_term = term_of(sg, e, m);
    end
  endtask

  task automatic cyc(input bit s, input int len, input bit st, input bit sg,
                     input int e, input int m);
    set = s; acc_len = len[7:0]; start_acc = st; sign_in = sg;
    exp_in = e[4:0]; mantissa_in = m[13:0];
    @(negedge clk);
    chk("acc_valid", {63'd0, acc_valid}, {63'd0, m_valid});
    chk("acc_out", {32'd0, acc_out}, {32'd0, m_out});
    chk("ovf_out", {63'd0, ovf_out}, {63'd0, m_ovf});
    chk("busy", {63'd0, busy}, {63'd0, (m_pend || m_cnt != 0)});
    model_edge(s, len, st, sg, e, m);
    @(posedge clk); #1;
  endtask

  task automatic strobe(input bit sg, input int e, input int m);
    cyc(0, 0, 1, sg, e, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset_acc_out", {32'd0, acc_out}, 64'd0);
    chk("reset_valid", {63'd0, acc_valid}, 64'd0);
    chk("reset_ovf", {63'd0, ovf_out}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // basic sum
    cyc(1, 4, 0, 0, 0, 0);
    repeat (4) strobe(0, 14, 4096);
    idle(3);
    chk("basic_sum", {32'd0, acc_out}, 64'd16384);

    // mixed signs and truncation
    cyc(1, 3, 0, 0, 0, 0);
    strobe(0, 14, 1); strobe(1, 15, 3); strobe(1, 13, 3);
    idle(3);
    chk("mixed_sum", {32'd0, acc_out}, 64'hFFFF_FFFA);

    // overflow
    cyc(1, 2, 0, 0, 0, 0);
    strobe(0, 31, 16383); strobe(0, 31, 16383);
    idle(3);
`ifdef ACC_SAT_EN
    chk("ovf_sum", {32'd0, acc_out}, 64'h7FFF_FFFF);
`else
    chk("ovf_sum", {32'd0, acc_out}, 64'hFFFC_0000);
`endif
    chk("ovf_flag", {63'd0, ovf_out}, 64'd1);
    cyc(1, 1, 0, 0, 0, 0);
    strobe(0, 14, 1);
    idle(3);
    chk("post_ovf_sum", {32'd0, acc_out}, 64'd1);
    chk("post_ovf_flag", {63'd0, ovf_out}, 64'd0);

    // set abort with a concurrent strobe
    cyc(1, 4, 0, 0, 0, 0);
    strobe(0, 14, 4096); strobe(0, 14, 4096);
    cyc(1, 4, 1, 0, 14, 4096);
    idle(4);
    chk("abort_hold", {32'd0, acc_out}, 64'd1);
    repeat (4) strobe(0, 14, 4096);
    idle(3);
    chk("abort_next_sum", {32'd0, acc_out}, 64'd16384);

    // back-to-back groups of one, including a negative zero
    cyc(1, 1, 0, 0, 0, 0);
    strobe(0, 14, 4096); strobe(1, 14, 4096); strobe(1, 20, 0);
    idle(3);
    chk("zero_term", {32'd0, acc_out}, 64'd0);

    // reset mid-group
    cyc(1, 5, 0, 0, 0, 0);
    strobe(0, 14, 7); strobe(0, 14, 9);
    set = 0; start_acc = 1; #2;
    rst = 1'b0; #1;
    chk("midrst_acc_out", {32'd0, acc_out}, 64'd0);
    chk("midrst_valid", {63'd0, acc_valid}, 64'd0);
    chk("midrst_ovf", {63'd0, ovf_out}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    model_reset();
    start_acc = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (256) strobe(0, 14, 1);
    idle(3);
    chk("default_len_sum", {32'd0, acc_out}, 64'd256);

    // randomized traffic
    cyc(1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 3)
        cyc(1, $urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 31), $urandom_range(0, 16383));
      else if ($urandom_range(0, 99) < 75)
        strobe($urandom_range(0, 1),
               ($urandom_range(0, 3) == 0) ? $urandom_range(28, 31) : $urandom_range(0, 31),
               ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 16383));
      else
        idle(1);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_int_acc_align.md
# fp_int_acc_align

Downstream accumulation stage for the bit-serial FP×INT multiplier. Each strobed product arrives as sign, 5-bit exponent and 14-bit unsigned mantissa. The block aligns the product to a common fixed-point grid, converts it to two's complement and adds it into an ACC_WIDTH signed accumulator. After a programmed number of products it presents the group sum with a one-cycle valid pulse and starts the next group from zero, with no gap between groups.

## Interface
- ACC_WIDTH, 32: accumulator and result width (signed). Must be ≥ 46 − SHIFT_DROP.
- SHIFT_DROP, 14: LSBs discarded after alignment (fixed-point fraction drop).
- LEN_WIDTH, 8: width of the group-length field.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- set  in  1  latch acc_len; abort and clear the current group.
- acc_len  in  LEN_WIDTH  products per group. 0 means 2^LEN_WIDTH.
- start_acc  in  1  product strobe. Each high cycle is one product.
- sign_in  in  1  product sign (1 = negative).
- exp_in  in  5  product exponent.
- mantissa_in  in  14  product magnitude.
- acc_out  out  ACC_WIDTH  last completed group sum.
- acc_valid  out  1  one-cycle pulse when acc_out updates.
- ovf_out  out  1  overflow occurred within the group now on acc_out.
- busy  out  1  group in progress or term in the pipeline.

## Operation
- Alignment (stage A): mag = ({mantissa_in} << exp_in) >> SHIFT_DROP. The shift is computed 45 bits wide, and truncation drops the low SHIFT_DROP bits of the magnitude. term = sign_in ? −mag : mag, sign-extended to ACC_WIDTH.
- Zero mantissa yields term 0 but still counts as a product, whatever the sign.
- Stage B: sum = acc + term (ACC_WIDTH signed). Overflow is flagged when acc and term have the same sign and sum has a different sign.
- Counter cnt (LEN_WIDTH bits) counts the terms added in the current group. A term is last when cnt == len_reg − 1, evaluated mod 2^LEN_WIDTH.
- On the last term:
  - acc_out ← sum (or the saturated value), ovf_out ← sticky | this overflow, acc_valid = 1.
  - acc, cnt and sticky clear to 0.
- On a non-last term: acc ← sum, cnt increments, sticky |= overflow.
- FSM states:
  - IDLE (cnt = 0, stage A empty) → ACCUM on the first start_acc.
  - ACCUM → IDLE when the last term is added and no new strobe is in stage A.
  - busy = (state == ACCUM) | stage-A valid.
- set (synchronous): len_reg ← acc_len. Clears acc, cnt, sticky and the stage-A valid; state → IDLE. acc_out and ovf_out hold their values.
- set has priority: a start_acc in the same cycle is dropped.

## Timing
- Reset (rst = 0, asynchronous): acc_out = 0, acc_valid = 0, ovf_out = 0, busy = 0. Internally len_reg = 0 (256 products), acc = 0, cnt = 0, stage A empty, state IDLE.
- Latency: a strobe in cycle t is registered in stage A at edge t+1 and added at edge t+2. For the last term, acc_valid is high in cycle t+2.
- Throughput is one product per cycle. Back-to-back groups are supported: the first term of group N+1 can sit in stage A while the last term of group N completes, and it is added onto zero.
- acc_valid stays high exactly one cycle per group and is never high for an aborted group.
- A set in cycle t, with a term in stage A, discards that term.
- Reset mid-group discards all partial state; no acc_valid is produced.

## Configuration
- ACC_SAT_EN defined:
  - On overflow, the value written (to acc or acc_out) is clamped to 2^(ACC_WIDTH−1)−1 for positive overflow or −2^(ACC_WIDTH−1) for negative overflow.
  - Accumulation continues from the clamped value.
  - ovf_out is still reported.
- ACC_SAT_EN undefined: two's-complement wrap; ovf_out is still reported.

## Test plan
- Basic sum:
  - Stimulus: acc_len = 4; four strobes with sign 0, exp 14, mant 4096.
  - Response: acc_out = 16384, acc_valid high exactly two cycles after the 4th strobe, ovf_out = 0.
- Mixed signs and truncation:
  - Stimulus: acc_len = 3; products (0, 14, 1), (1, 15, 3) and (1, 13, 3).
  - Response: terms +1, −6, −1, giving acc_out = −6 (0xFFFFFFFA).
- Overflow:
  - Stimulus: acc_len = 2; two strobes with sign 0, exp 31, mant 16383 (term 2147352576 each).
  - Response without ACC_SAT_EN: acc_out = −262144 (0xFFFC0000), ovf_out = 1.
  - Response with ACC_SAT_EN: acc_out = 0x7FFFFFFF, ovf_out = 1.
  - A following group of one +1 product gives acc_out = 1, ovf_out = 0.
- Set abort:
  - Stimulus: acc_len = 4; set is asserted after 2 strobes, concurrent with a 3rd strobe.
  - Response: no acc_valid. The next 4 strobes of +4096 give acc_out = 16384. acc_out holds its previous value until then.
- Back-to-back and zero terms:
  - Stimulus: acc_len = 1; continuous strobes +4096, −4096, then mantissa 0 with sign 1.
  - Response: acc_valid high 3 consecutive cycles with acc_out = 4096, −4096, 0.
- Reset mid-operation:
  - Stimulus: rst is pulled low while busy = 1.
  - Response: all outputs are 0 immediately. After release, acc_len defaults to 256, and 256 strobes of +1 give acc_out = 256.
